// File: rtl/fds_pkg.sv
// fds_pkg: shared definitions for the serial adder.
//   state_e : two-state FSM encoding (ST_IDLE / ST_RUN)
//   cnt_w() : digit-counter width for a given digit count, never less than 1 bit
package fds_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   function automatic int unsigned cnt_w(input int unsigned ndig);
      return (ndig > 1) ? $clog2(ndig) : 1;
   endfunction

endpackage

// File: rtl/adder_slice.sv
// adder_slice: purely combinational DIGIT-bit ripple chain of full-adder cells.
//   x, y   in  DIGIT  addends
//   cin    in  1      carry into bit 0
//   s      out DIGIT  sum
//   cout   out 1      carry out of the top bit
//   c_msb  out 1      carry into the top bit (used for signed overflow)
module adder_slice #(
   parameter int unsigned DIGIT = 4
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             cin,
   output logic [DIGIT-1:0] s,
   output logic             cout,
   output logic             c_msb
);

   logic carry;

   // Carry is a block-local running value so the ripple has no vector feedback.
   always_comb begin
      carry = cin;
      c_msb = cin;
      s     = '0;
      for (int i = 0; i < int'(DIGIT); i++) begin
         c_msb = carry;
         s[i]  = x[i] ^ y[i] ^ carry;
         carry = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
      end
      cout = carry;
   end

endmodule

// File: rtl/serial_adder_n.sv
// serial_adder_n: multi-cycle WIDTH-bit adder/subtractor, DIGIT bits per clock, LSB digit first.
//   clk, rst_n  clock (rising edge) and asynchronous active-low reset
//   start       request, sampled only while idle
//   sub         0: a+b+cin, 1: a-b
//   a, b, cin   operands, captured on the accepted start edge
//   busy        operation in progress
//   done        one-cycle pulse, result valid
//   s           result, held until the next accepted start
//   cout        final carry out of the MSB (sub: 1 = no borrow)
//   ovf         signed overflow
module serial_adder_n
   import fds_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned NDIG  = WIDTH / DIGIT;
   localparam int unsigned CNT_W = cnt_w(NDIG);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, s_q;
   logic [CNT_W-1:0] cnt_q;
   logic             carry_q, cout_q, ovf_q, done_q;

   logic [DIGIT-1:0] sl_s;
   logic             sl_cout, sl_cmsb;
   logic             accept, last;

   assign accept = (state_q == ST_IDLE) && start;
   assign last   = (state_q == ST_RUN) && (cnt_q == LAST_CNT);

   // Operands shift right each cycle, so the slice always sees the low digit.
   adder_slice #(
      .DIGIT (DIGIT)
   ) u_slice (
      .x     (a_q[DIGIT-1:0]),
      .y     (b_q[DIGIT-1:0]),
      .cin   (carry_q),
      .s     (sl_s),
      .cout  (sl_cout),
      .c_msb (sl_cmsb)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN:  if (cnt_q == LAST_CNT) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            // Subtract as a + ~b + 1.
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            cnt_q   <= '0;
            s_q     <= '0;
         end else if (state_q == ST_RUN) begin
            a_q     <= a_q >> DIGIT;
            b_q     <= b_q >> DIGIT;
            carry_q <= sl_cout;
            // s was cleared at start and each digit lands once, so OR-in is a digit write.
            s_q     <= s_q | (WIDTH'(sl_s) << (cnt_q * DIGIT));
            if (last) begin
               cnt_q  <= '0;
               cout_q <= sl_cout;
               ovf_q  <= sl_cout ^ sl_cmsb;
               done_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end
   end

   assign busy = (state_q == ST_RUN);
   assign done = done_q;
   assign s    = s_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule
